// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debounce block.
// Default timing constants assume a 50 MHz system clock.
package key_pkg;

    localparam int KEY_DEB_20MS_50M = 1_000_000;
    localparam int KEY_LONG_1S_50M  = 50_000_000;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input longint n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, stability counter, strobes.
// Long-press hold counter is built only with KEY_DEBOUNCE_LONG_EN.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEB_CYCLES  = KEY_DEB_20MS_50M,
    parameter int LONG_CYCLES = KEY_LONG_1S_50M,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int   DEB_W    = cnt_width(longint'(DEB_CYCLES));
    localparam logic RELEASED = (ACTIVE_LOW != 0);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [1:0]       sync;
    logic             pressed_s;
    logic [DEB_W-1:0] deb_cnt;

    // Two-stage synchroniser, parked at the released raw level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {RELEASED, RELEASED};
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign pressed_s = sync[1] ^ RELEASED;

    // Restart-on-bounce window; level flips once the window completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt     <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            if (pressed_s == key_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_cnt     <= '0;
                key_level   <= pressed_s;
                key_press   <= pressed_s;
                key_release <= ~pressed_s;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

`ifdef KEY_DEBOUNCE_LONG_EN
    localparam int HOLD_W = cnt_width(longint'(LONG_CYCLES) + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Saturating hold timer; strobe fires once on reaching the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            key_long <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (!key_level) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                key_long <= (hold_cnt == HOLD_LAST);
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// Multi-channel push-button conditioner, one channel per key.
// Optional long-press strobe: define KEY_DEBOUNCE_LONG_EN.
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = KEY_DEB_20MS_50M,
    parameter int LONG_CYCLES = KEY_LONG_1S_50M,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule
